// File: rtl/list_cmd_ctrl.sv
// list_cmd_ctrl
//   Command front-end for one list instance. Commands arrive on a valid/ready
//   stream and are buffered in a small command FIFO. A three-state sequencer
//   (IDLE -> WAIT -> GAP) issues them one at a time on the list op port. It
//   gathers op_done / op_error / data_out into a response FIFO that is drained
//   through a valid/ready stream. SEARCH_ALL produces one beat per match plus a
//   closing beat. Every command yields exactly one beat with rsp_last=1.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   cmd_valid/ready     command stream handshake (ready = command FIFO not full)
//   cmd_op/data/index   op code, insert value or search key, element index
//   rsp_valid/ready     response stream handshake (valid = response FIFO not empty)
//   rsp_data            read value / sum / match index, 0 for insert/delete/sort
//   rsp_error/last/op   error flag, final-beat flag, echo of the command op
//   l_op_sel/l_op_en    op select and single-cycle start pulse to the list
//   l_data_in/index_in  op operands, held stable from issue until the next issue
//   l_data_out, l_op_done, l_op_in_prog, l_op_error, l_len   list status
module list_cmd_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int LENGTH     = 8,
  parameter int CMD_DEPTH  = 4,
  parameter int RSP_DEPTH  = 16,
  localparam int LW        = $clog2(LENGTH),
  localparam int LENW      = $clog2(LENGTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_op,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  input  logic [LW-1:0]         cmd_index,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [LW+DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_error,
  output logic                  rsp_last,
  output logic [2:0]            rsp_op,
  output logic [2:0]            l_op_sel,
  output logic                  l_op_en,
  output logic [DATA_WIDTH-1:0] l_data_in,
  output logic [LW-1:0]         l_index_in,
  input  logic [LW+DATA_WIDTH-1:0] l_data_out,
  input  logic                  l_op_done,
  input  logic                  l_op_in_prog,
  input  logic                  l_op_error,
  input  logic [LENW-1:0]       l_len
);

  localparam int RW  = LW + DATA_WIDTH;
  localparam int RE  = RW + 5;                 // {data, error, last, op}
  localparam int CAW = $clog2(CMD_DEPTH);
  localparam int CCW = $clog2(CMD_DEPTH + 1);
  localparam int RAW = $clog2(RSP_DEPTH);
  localparam int RCW = $clog2(RSP_DEPTH + 1);

  localparam logic [2:0] OP_SEARCH_ALL = 3'd2;
  localparam logic [2:0] OP_SEARCH_1ST = 3'd3;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_GAP} state_t;

  function automatic logic is_search(input logic [2:0] op);
    return (op == OP_SEARCH_ALL) || (op == OP_SEARCH_1ST);
  endfunction

  // Command FIFO
  logic [2:0]            cmd_op_mem   [CMD_DEPTH];
  logic [DATA_WIDTH-1:0] cmd_data_mem [CMD_DEPTH];
  logic [LW-1:0]         cmd_idx_mem  [CMD_DEPTH];
  logic [CAW-1:0]        cmd_wr_ptr, cmd_rd_ptr;
  logic [CCW-1:0]        cmd_cnt;
  logic                  cmd_push, cmd_pop, cmd_empty;
  logic [2:0]            hd_op;
  logic [DATA_WIDTH-1:0] hd_data;
  logic [LW-1:0]         hd_index;

  // No bypass: a full FIFO stays not-ready even when the head is popped this cycle.
  assign cmd_ready = (cmd_cnt != CCW'(CMD_DEPTH));
  assign cmd_push  = cmd_valid & cmd_ready;
  assign cmd_empty = (cmd_cnt == '0);
  assign hd_op     = cmd_op_mem[cmd_rd_ptr];
  assign hd_data   = cmd_data_mem[cmd_rd_ptr];
  assign hd_index  = cmd_idx_mem[cmd_rd_ptr];

  always_ff @(posedge clk) begin
    if (cmd_push) begin
      cmd_op_mem[cmd_wr_ptr]   <= cmd_op;
      cmd_data_mem[cmd_wr_ptr] <= cmd_data;
      cmd_idx_mem[cmd_wr_ptr]  <= cmd_index;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_wr_ptr <= '0;
      cmd_rd_ptr <= '0;
      cmd_cnt    <= '0;
    end else begin
      if (cmd_push) cmd_wr_ptr <= cmd_wr_ptr + CAW'(1);
      if (cmd_pop)  cmd_rd_ptr <= cmd_rd_ptr + CAW'(1);
      case ({cmd_push, cmd_pop})
        2'b10:   cmd_cnt <= cmd_cnt + CCW'(1);
        2'b01:   cmd_cnt <= cmd_cnt - CCW'(1);
        default: cmd_cnt <= cmd_cnt;
      endcase
    end
  end

  // Response FIFO
  logic [RE-1:0]  rsp_mem [RSP_DEPTH];
  logic [RAW-1:0] rsp_wr_ptr, rsp_rd_ptr;
  logic [RCW-1:0] rsp_cnt;
  logic           rsp_push, rsp_pop, rsp_room;
  logic [RE-1:0]  rsp_wdata;

  assign rsp_valid = (rsp_cnt != '0);
  assign rsp_pop   = rsp_valid & rsp_ready;
  // Issue only with room for the worst case: LENGTH match beats plus the final beat.
  // This means WAIT never needs to stall the list.
  assign rsp_room  = (rsp_cnt <= RCW'(RSP_DEPTH - LENGTH - 1));

  // Outputs read zero while empty so the stream is clean out of reset.
  assign {rsp_data, rsp_error, rsp_last, rsp_op} =
    rsp_valid ? rsp_mem[rsp_rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rsp_push) rsp_mem[rsp_wr_ptr] <= rsp_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_wr_ptr <= '0;
      rsp_rd_ptr <= '0;
      rsp_cnt    <= '0;
    end else begin
      if (rsp_push) rsp_wr_ptr <= rsp_wr_ptr + RAW'(1);
      if (rsp_pop)  rsp_rd_ptr <= rsp_rd_ptr + RAW'(1);
      case ({rsp_push, rsp_pop})
        2'b10:   rsp_cnt <= rsp_cnt + RCW'(1);
        2'b01:   rsp_cnt <= rsp_cnt - RCW'(1);
        default: rsp_cnt <= rsp_cnt;
      endcase
    end
  end

  // Sequencer
  state_t          state;
  logic [LENW-1:0] match_cnt;
  logic            search_empty;

  // A search on an empty list is answered locally and never reaches the list.
  assign search_empty = is_search(hd_op) && (l_len == '0);

  always_comb begin
    cmd_pop   = 1'b0;
    rsp_push  = 1'b0;
    rsp_wdata = '0;
    case (state)
      ST_IDLE: begin
        if (!cmd_empty && rsp_room) begin
          cmd_pop = 1'b1;
          if (search_empty) begin
            rsp_push  = 1'b1;
            rsp_wdata = {RW'(0), 1'b1, 1'b1, hd_op};
          end
        end
      end
      ST_WAIT: begin
        if (l_op_done) begin
          rsp_push = 1'b1;
          if (l_op_in_prog)
            rsp_wdata = {l_data_out, 1'b0, 1'b0, l_op_sel};
          else if (l_op_sel == OP_SEARCH_ALL)
            rsp_wdata = {RW'(0), (match_cnt == '0), 1'b1, l_op_sel};
          else
            rsp_wdata = {l_data_out, l_op_error, 1'b1, l_op_sel};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      l_op_en    <= 1'b0;
      l_op_sel   <= '0;
      l_data_in  <= '0;
      l_index_in <= '0;
      match_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_pop) begin
            if (search_empty) begin
              state <= ST_GAP;
            end else begin
              l_op_sel   <= hd_op;
              l_data_in  <= hd_data;
              l_index_in <= hd_index;
              l_op_en    <= 1'b1;
              match_cnt  <= '0;
              state      <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          l_op_en <= 1'b0;
          if (l_op_done) begin
            if (l_op_in_prog) match_cnt <= match_cnt + LENW'(1);
            else              state     <= ST_GAP;
          end
        end
        // The list sits in its done state for one cycle and ignores op_en there.
        ST_GAP:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_list_cmd_ctrl.sv
// Directed bench for list_cmd_ctrl with a behavioural list model as responder.
// Op codes used: 0 read, 1 insert, 2 search-all, 3 search-first, 4 sum, 7 delete.
module tb_list_cmd_ctrl;
  localparam int DW  = 32;
  localparam int LEN = 8;
  localparam int LW  = 3;
  localparam int RW  = LW + DW;
  localparam logic [2:0] OP_RD = 3'd0, OP_INS = 3'd1, OP_SALL = 3'd2,
                         OP_S1 = 3'd3, OP_SUM = 3'd4, OP_DEL = 3'd7;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [2:0]    cmd_op = '0;
  logic [DW-1:0] cmd_data = '0;
  logic [LW-1:0] cmd_index = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [RW-1:0] rsp_data;
  logic          rsp_error, rsp_last;
  logic [2:0]    rsp_op;
  logic [2:0]    l_op_sel;
  logic          l_op_en;
  logic [DW-1:0] l_data_in;
  logic [LW-1:0] l_index_in;
  logic [RW-1:0] l_data_out;
  logic          l_op_done, l_op_in_prog, l_op_error;
  logic [3:0]    l_len;

  list_cmd_ctrl #(.DATA_WIDTH(DW), .LENGTH(LEN), .CMD_DEPTH(4), .RSP_DEPTH(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .cmd_index(cmd_index),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_error(rsp_error), .rsp_last(rsp_last), .rsp_op(rsp_op),
    .l_op_sel(l_op_sel), .l_op_en(l_op_en), .l_data_in(l_data_in),
    .l_index_in(l_index_in), .l_data_out(l_data_out), .l_op_done(l_op_done),
    .l_op_in_prog(l_op_in_prog), .l_op_error(l_op_error), .l_len(l_len)
  );

  always #5 clk = ~clk;

  // Behavioural list: single-cycle ops, search-all scans one element per cycle.
  logic [DW-1:0] lm [0:LEN-1];
  logic [3:0]    llen;
  logic          scanning;
  logic [3:0]    sidx;
  logic [DW-1:0] skey;
  logic [RW-1:0] sum_v, first_v;
  logic          found_v;

  assign l_len = llen;

  always_comb begin
    sum_v   = '0;
    first_v = '0;
    found_v = 1'b0;
    for (int k = 0; k < LEN; k++) begin
      if (k < int'(llen)) begin
        sum_v = sum_v + RW'(lm[k]);
        if (!found_v && lm[k] == l_data_in) begin
          found_v = 1'b1;
          first_v = RW'(k);
        end
      end
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      llen <= '0; scanning <= 1'b0; sidx <= '0; skey <= '0;
      l_op_done <= 1'b0; l_op_in_prog <= 1'b0; l_op_error <= 1'b0; l_data_out <= '0;
    end else begin
      l_op_done <= 1'b0; l_op_in_prog <= 1'b0; l_op_error <= 1'b0; l_data_out <= '0;
      if (scanning) begin
        if (sidx < llen) begin
          if (lm[sidx[2:0]] == skey) begin
            l_op_done <= 1'b1; l_op_in_prog <= 1'b1; l_data_out <= RW'(sidx);
          end
          sidx <= sidx + 4'd1;
        end else begin
          l_op_done <= 1'b1;
          scanning  <= 1'b0;
        end
      end else if (l_op_en) begin
        case (l_op_sel)
          OP_RD: begin
            l_op_done <= 1'b1;
            if ({1'b0, l_index_in} < llen) l_data_out <= RW'(lm[l_index_in]);
            else l_op_error <= 1'b1;
          end
          OP_INS: begin
            l_op_done <= 1'b1;
            if (int'(llen) == LEN || {1'b0, l_index_in} > llen) l_op_error <= 1'b1;
            else begin
              for (int k = 1; k < LEN; k++)
                if (k > int'(l_index_in)) lm[k] <= lm[k-1];
              lm[l_index_in] <= l_data_in;
              llen <= llen + 4'd1;
            end
          end
          OP_SALL: begin
            scanning <= 1'b1; sidx <= '0; skey <= l_data_in;
          end
          OP_S1: begin
            l_op_done <= 1'b1;
            if (found_v) l_data_out <= first_v; else l_op_error <= 1'b1;
          end
          OP_SUM: begin
            l_op_done <= 1'b1; l_data_out <= sum_v;
          end
          OP_DEL: begin
            l_op_done <= 1'b1;
            if ({1'b0, l_index_in} < llen) begin
              for (int k = 0; k < LEN - 1; k++)
                if (k >= int'(l_index_in)) lm[k] <= lm[k+1];
              llen <= llen - 4'd1;
            end else l_op_error <= 1'b1;
          end
          default: l_op_done <= 1'b1;
        endcase
      end
    end
  end

  int en_cnt = 0;
  always @(posedge clk) if (l_op_en) en_cnt <= en_cnt + 1;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [2:0] op, input logic [DW-1:0] d, input logic [LW-1:0] idx);
    int t = 0;
    @(negedge clk);
    while (!cmd_ready && t < 200) begin @(negedge clk); t++; end
    if (!cmd_ready) chk("send_ready_timeout", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d; cmd_index = idx;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic pop(input string tag, input logic [RW-1:0] d, input logic e,
                     input logic l, input logic [2:0] op);
    int t = 0;
    while (!rsp_valid && t < 200) begin @(negedge clk); t++; end
    chk(tag, 64'({rsp_data, rsp_error, rsp_last, rsp_op}), 64'({d, e, l, op}));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int t;
    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_op_en", 64'(l_op_en), 64'd0);
    chk("rst_op_sel", 64'(l_op_sel), 64'd0);
    chk("rst_data_in", 64'(l_data_in), 64'd0);
    chk("rst_index_in", 64'(l_index_in), 64'd0);
    chk("rst_rsp_fields", 64'({rsp_data, rsp_error, rsp_last, rsp_op}), 64'd0);

    // T1: insert 5@0, insert 9@1, read idx1
    send(OP_INS, 32'd5, 3'd0);
    send(OP_INS, 32'd9, 3'd1);
    send(OP_RD, 32'hAB, 3'd1);
    pop("t1_ins0", '0, 1'b0, 1'b1, OP_INS);
    pop("t1_ins1", '0, 1'b0, 1'b1, OP_INS);
    pop("t1_read", 35'd9, 1'b0, 1'b1, OP_RD);
    chk("t1_index_held", 64'(l_index_in), 64'd1);
    chk("t1_data_held", 64'(l_data_in), 64'hAB);

    // T2: build {3,7,3,3}, search-all key 3
    send(OP_DEL, 32'd0, 3'd0);
    send(OP_DEL, 32'd0, 3'd0);
    pop("t2_del0", '0, 1'b0, 1'b1, OP_DEL);
    pop("t2_del1", '0, 1'b0, 1'b1, OP_DEL);
    send(OP_INS, 32'd3, 3'd0);
    send(OP_INS, 32'd7, 3'd1);
    send(OP_INS, 32'd3, 3'd2);
    send(OP_INS, 32'd3, 3'd3);
    for (int i = 0; i < 4; i++) pop("t2_ins", '0, 1'b0, 1'b1, OP_INS);
    send(OP_SALL, 32'd3, 3'd0);
    pop("t2_match0", 35'd0, 1'b0, 1'b0, OP_SALL);
    pop("t2_match2", 35'd2, 1'b0, 1'b0, OP_SALL);
    pop("t2_match3", 35'd3, 1'b0, 1'b0, OP_SALL);
    pop("t2_sall_last", '0, 1'b0, 1'b1, OP_SALL);
    send(OP_SALL, 32'd8, 3'd0);
    pop("t2_sall_nomatch", '0, 1'b1, 1'b1, OP_SALL);
    send(OP_S1, 32'd7, 3'd0);
    pop("t2_s1st", 35'd1, 1'b0, 1'b1, OP_S1);

    // T3: empty list searches are answered without touching the list
    for (int i = 0; i < 4; i++) send(OP_DEL, 32'd0, 3'd0);
    for (int i = 0; i < 4; i++) pop("t3_del", '0, 1'b0, 1'b1, OP_DEL);
    e0 = en_cnt;
    send(OP_S1, 32'd4, 3'd0);
    pop("t3_s1_empty", '0, 1'b1, 1'b1, OP_S1);
    chk("t3_no_issue_s1", 64'(en_cnt), 64'(e0));
    send(OP_SALL, 32'd4, 3'd0);
    pop("t3_sall_empty", '0, 1'b1, 1'b1, OP_SALL);
    chk("t3_no_issue_sall", 64'(en_cnt), 64'(e0));

    // T5: fill to capacity, overflow insert, sum 1..8
    for (int i = 0; i < LEN; i++) send(OP_INS, DW'(i + 1), LW'(i));
    for (int i = 0; i < LEN; i++) pop("t5_fill", '0, 1'b0, 1'b1, OP_INS);
    send(OP_INS, 32'd99, 3'd0);
    pop("t5_overflow", '0, 1'b1, 1'b1, OP_INS);
    send(OP_SUM, 32'd0, 3'd0);
    pop("t5_sum", 35'd36, 1'b0, 1'b1, OP_SUM);

    // T4: back-pressure; issue stops once free slots drop below LENGTH+1
    e0 = en_cnt;
    for (int i = 0; i < 7; i++) send(OP_RD, 32'd0, LW'(i));
    send(OP_RD, 32'd0, 3'd7);
    send(OP_RD, 32'd0, 3'd0);
    send(OP_RD, 32'd0, 3'd1);
    send(OP_RD, 32'd0, 3'd2);
    send(OP_RD, 32'd0, 3'd3);
    repeat (20) @(negedge clk);
    chk("t4_issued_held", 64'(en_cnt - e0), 64'd8);
    chk("t4_cmd_full", 64'(cmd_ready), 64'd0);
    chk("t4_rsp_pending", 64'(rsp_valid), 64'd1);
    for (int i = 0; i < 7; i++) pop("t4_read_a", RW'(i + 1), 1'b0, 1'b1, OP_RD);
    pop("t4_read_7", 35'd8, 1'b0, 1'b1, OP_RD);
    for (int i = 0; i < 4; i++) pop("t4_read_b", RW'(i + 1), 1'b0, 1'b1, OP_RD);
    chk("t4_issued_all", 64'(en_cnt - e0), 64'd12);
    chk("t4_cmd_drained", 64'(cmd_ready), 64'd1);

    // T6: reset in the middle of a search-all
    send(OP_SALL, 32'd8, 3'd0);
    t = 0;
    while (!l_op_en && t < 50) begin @(negedge clk); t++; end
    chk("t6_issue_seen", 64'(l_op_en), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t6_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("t6_rst_op_en", 64'(l_op_en), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_cmd_ready", 64'(cmd_ready), 64'd1);
    repeat (10) @(negedge clk);
    chk("t6_no_partial", 64'(rsp_valid), 64'd0);
    send(OP_RD, 32'd0, 3'd0);
    pop("t6_read_empty", '0, 1'b1, 1'b1, OP_RD);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
